// File: rtl/tm1638_pkg.sv
// Shared opcodes, command-byte field positions and state encoding for the TM1638 responder.
package tm1638_pkg;

  localparam logic [7:0] C_READ  = 8'h42;
  localparam logic [7:0] C_WRITE = 8'h40;
  localparam logic [7:0] C_DISP  = 8'h8F;
  localparam logic [7:0] C_ADDR  = 8'hC0;

  localparam int unsigned OpMsb     = 7;
  localparam int unsigned OpLsb     = 6;
  localparam int unsigned FixedBit  = 2;
  localparam int unsigned ReadBit   = 1;
  localparam int unsigned DispOnBit = 3;
  localparam int unsigned AddrMsb   = 3;
  localparam int unsigned BriMsb    = 2;

  typedef enum logic [1:0] {
    OpNone = 2'b00,
    OpData = 2'b01,
    OpDisp = 2'b10,
    OpAddr = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StWdata,
    StRdata,
    StIgnore
  } state_e;

endpackage

// File: rtl/tm1638_if.sv
// Three-wire STB/CLK/DIO link; the host is master, the responder is slave.
interface tm1638_if;
  logic stb_n;
  logic sclk;
  logic dio_in;
  logic dio_out;
  logic dio_oe;

  modport master (output stb_n, output sclk, output dio_in, input dio_out, input dio_oe);
  modport slave  (input stb_n, input sclk, input dio_in, output dio_out, output dio_oe);
endinterface

// File: rtl/tm1638_pin_sync.sv
// Two-flop synchronizers for stb_n/sclk/dio plus registered edge detect (3-cycle pin latency).
module tm1638_pin_sync (
  input  logic div_clk,
  input  logic rst,
  input  logic stb_n,
  input  logic sclk,
  input  logic dio_in,
  output logic stb_rise,
  output logic stb_fall,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic dio_s
);

  // Bit order in the vectors: {dio, sclk, stb}
  logic [2:0] meta;
  logic [2:0] sync;
  logic [1:0] prev;

  always_ff @(posedge div_clk) begin
    if (rst) begin
      meta      <= 3'b111;
      sync      <= 3'b111;
      prev      <= 2'b11;
      stb_rise  <= 1'b0;
      stb_fall  <= 1'b0;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      dio_s     <= 1'b1;
    end else begin
      meta      <= {dio_in, sclk, stb_n};
      sync      <= meta;
      prev      <= sync[1:0];
      stb_rise  <= sync[0] & ~prev[0];
      stb_fall  <= ~sync[0] & prev[0];
      sclk_rise <= sync[1] & ~prev[1];
      sclk_fall <= ~sync[1] & prev[1];
      // Delayed to stay aligned with the sclk edge pulses
      dio_s     <= sync[2];
    end
  end

endmodule

// File: rtl/tm1638_responder.sv
// TM1638 chip-side emulation: display RAM, display control and key-scan readback.
// Key readback path is built only when TM1638_RESP_KEYS_EN is defined.
module tm1638_responder
  import tm1638_pkg::*;
(
  input  logic          div_clk,
  input  logic          rst,
  tm1638_if.slave       link,
  input  logic [31:0]   key_state,
  output logic [127:0]  disp_ram,
  output logic          disp_on,
  output logic [2:0]    brightness,
  output logic          frame_done,
  output logic          cmd_err
);

  logic stb_rise, stb_fall, sclk_rise, sclk_fall, dio_s;

  tm1638_pin_sync u_pin_sync (
    .div_clk   (div_clk),
    .rst       (rst),
    .stb_n     (link.stb_n),
    .sclk      (link.sclk),
    .dio_in    (link.dio_in),
    .stb_rise  (stb_rise),
    .stb_fall  (stb_fall),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .dio_s     (dio_s)
  );

  state_e     state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic [3:0] addr;
  logic       fixed_addr;
  logic       byte_seen;
  logic       drive_val;
  logic       drive_en;
  logic [7:0] rx_byte;

`ifdef TM1638_RESP_KEYS_EN
  logic [31:0] key_sh;
  logic [5:0]  rd_cnt;
`else
  logic unused_keys;
  assign unused_keys = ^key_state;
`endif

  // LSB first: the newest bit enters at the top
  assign rx_byte      = {dio_s, shreg[7:1]};
  assign link.dio_out = drive_val;
  assign link.dio_oe  = drive_en;

  always_ff @(posedge div_clk) begin
    if (rst) begin
      state      <= StIdle;
      bit_cnt    <= 3'd0;
      shreg      <= 8'd0;
      addr       <= 4'd0;
      fixed_addr <= 1'b0;
      byte_seen  <= 1'b0;
      drive_val  <= 1'b1;
      drive_en   <= 1'b0;
      disp_ram   <= '0;
      disp_on    <= 1'b0;
      brightness <= 3'd0;
      frame_done <= 1'b0;
      cmd_err    <= 1'b0;
`ifdef TM1638_RESP_KEYS_EN
      key_sh     <= 32'd0;
      rd_cnt     <= 6'd0;
`endif
    end else begin
      frame_done <= 1'b0;
      cmd_err    <= 1'b0;
      if (stb_rise) begin
        state      <= StIdle;
        drive_en   <= 1'b0;
        drive_val  <= 1'b1;
        frame_done <= byte_seen;
        byte_seen  <= 1'b0;
      end else if (stb_fall) begin
        state     <= StCmd;
        bit_cnt   <= 3'd0;
        byte_seen <= 1'b0;
        drive_en  <= 1'b0;
        drive_val <= 1'b1;
      end else begin
        unique case (state)
          StCmd: begin
            if (sclk_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                byte_seen <= 1'b1;
                unique case (op_e'(rx_byte[OpMsb:OpLsb]))
                  OpData: begin
                    fixed_addr <= rx_byte[FixedBit];
                    state      <= StIgnore;
`ifdef TM1638_RESP_KEYS_EN
                    if (rx_byte[ReadBit]) begin
                      state  <= StRdata;
                      key_sh <= key_state;
                      rd_cnt <= 6'd0;
                    end
`endif
                  end
                  OpAddr: begin
                    addr  <= rx_byte[AddrMsb:0];
                    state <= StWdata;
                  end
                  OpDisp: begin
                    disp_on    <= rx_byte[DispOnBit];
                    brightness <= rx_byte[BriMsb:0];
                    state      <= StIgnore;
                  end
                  default: begin
                    cmd_err <= 1'b1;
                    state   <= StIgnore;
                  end
                endcase
              end
            end
          end
          StWdata: begin
            if (sclk_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                byte_seen                   <= 1'b1;
                disp_ram[{addr, 3'b000} +: 8] <= rx_byte;
                if (!fixed_addr) addr <= addr + 4'd1;
              end
            end
          end
          StRdata: begin
`ifdef TM1638_RESP_KEYS_EN
            if (sclk_fall) begin
              // The fall after the 32nd bit hands DIO back to the pull-up
              if (rd_cnt == 6'd32) begin
                drive_en  <= 1'b0;
                drive_val <= 1'b1;
                state     <= StIgnore;
              end else begin
                drive_en  <= 1'b1;
                drive_val <= key_sh[0];
                key_sh    <= {1'b1, key_sh[31:1]};
                rd_cnt    <= rd_cnt + 6'd1;
              end
            end
`else
            state <= StIgnore;
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule
